i2c_cfg_sequencer: RTL
======================

// Module: i2c_cfg_sequencer
// PURPOSE
//  Upstream command source for the I2C write transmitter (start/addr/ack/data1/ack/data2/ack/stop engine).
//  Walks a fixed table of 16-bit codec register writes after power-up and hands each one to the transmitter as {dev addr, data1, data2}.
//  Tracks transmitter completion and NACK, retries failed writes, reports overall done/error to the top level.
// PARAMETERS
//  NUM_REGS      11       number of table entries sent, 1..32
//  DEV_ADDR      7'h1A    7-bit slave address driven on every transaction
//  INIT_DELAY    50000    clk cycles waited after reset/start before first write
//  TIMEOUT       4096     clk cycles allowed from tx_req to tx_done before treating the write as NACK
//  MAX_RETRY     3        retries per entry (only used with I2C_CFG_RETRY_EN)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  start         in   1   1-cycle pulse: (re)run the whole table from entry 0
//  tx_req        out  1   1-cycle pulse: transmitter latches tx_dev_addr/tx_data1/tx_data2
//  tx_dev_addr   out  7   slave address (constant DEV_ADDR)
//  tx_data1      out  8   table word [15:8]
//  tx_data2      out  8   table word [7:0]
//  tx_done       in   1   1-cycle pulse from transmitter after stop condition
//  tx_nack       in   1   valid with tx_done: 1 = any of the three acks missing
//  reg_index     out  5   entry currently being sent
//  cfg_done      out  1   high (level) once all entries acked
//  cfg_error     out  1   high (level) when an entry finally failed
// BEHAVIOUR
//  Reset: state IDLE_S, tx_req=0, reg_index=0, cfg_done=0, cfg_error=0, tx_data*=0, counters=0. Reset mid-transaction aborts at once; late tx_done ignored.
//  Reset release acts as an implicit start (auto-config at power-up).
//  States / transitions:
//   IDLE_S    -> DELAY_S on start or first cycle after reset.
//   DELAY_S   count INIT_DELAY cycles -> LOAD_S (reg_index=0).
//   LOAD_S    register table word for reg_index onto tx_data1/2 -> REQ_S (1 cycle).
//   REQ_S     assert tx_req for exactly 1 cycle, clear timeout counter -> WAIT_S.
//   WAIT_S    tx_done&!tx_nack -> NEXT_S; tx_done&tx_nack or timeout==TIMEOUT-1 -> FAIL_S.
//   FAIL_S    retry_cnt<MAX_RETRY: retry_cnt++ -> REQ_S (same data); else -> ERROR_S.
//   NEXT_S    retry_cnt=0; reg_index==NUM_REGS-1 -> DONE_S, else reg_index++ -> LOAD_S.
//   DONE_S    cfg_done=1; hold until start.   ERROR_S  cfg_error=1; hold until start.
//  start in DONE_S/ERROR_S/IDLE_S: clear cfg_done/cfg_error, reg_index=0, -> DELAY_S. start in any other state ignored.
//  tx_done outside WAIT_S ignored. tx_done and timeout on same cycle: tx_done wins.
//  Outputs tx_data1/2 stable from LOAD_S until next LOAD_S; tx_dev_addr constant.
//  Min spacing between tx_req pulses: 3 cycles. Latency tx_done -> next tx_req: 3 cycles (NEXT_S, LOAD_S, REQ_S).
//  Timeout counter width clog2(TIMEOUT); saturates, never wraps. reg_index never exceeds NUM_REGS-1.
// CONFIGURATION
//  I2C_CFG_RETRY_EN defined: FAIL_S retries up to MAX_RETRY times per entry (total MAX_RETRY+1 attempts).
//  Not defined: FAIL_S -> ERROR_S immediately on first NACK/timeout; retry counter not built; MAX_RETRY unused.
// STRUCTURE
//  Shared header/package i2c_cfg_pkg: state encodings (IDLE_S..ERROR_S, 4 bits), table word width (16), default DEV_ADDR.
//  Sub-module i2c_cfg_rom: combinational case lookup index[4:0] -> word[15:0]; out-of-range index returns 16'h0000.
//  Sequencer = state register + next-state always block + counters (delay/timeout shared, retry, index).
// TESTING
//  1 reset, INIT_DELAY=10, bench acks all -> first tx_req at cycle 12 after reset; 11 tx_req pulses; data matches rom; cfg_done=1, cfg_error=0.
//  2 NACK entry 4 twice then ack (RETRY_EN, MAX_RETRY=3) -> 3 tx_req with reg_index=4, identical data; sequence completes, cfg_done=1.
//  3 NACK entry 2 always (RETRY_EN) -> exactly 4 attempts, cfg_error=1, reg_index=2, no further tx_req; without macro -> 1 attempt then error.
//  4 never pulse tx_done, TIMEOUT=16 -> FAIL_S 16 cycles after WAIT_S entry; behaves as NACK.
//  5 reset asserted in WAIT_S of entry 6, stray tx_done after release -> ignored; sequence restarts at entry 0 after INIT_DELAY.
//  6 start pulse in DONE_S -> cfg_done drops next cycle, full table resent; start pulse in WAIT_S -> no effect.

Source files
------------

// File: rtl/i2c_cfg_sequencer_pkg.sv
// Shared definitions for the I2C codec configuration sequencer:
// FSM state encoding, table word width and default slave address.
package i2c_cfg_pkg;

  localparam int unsigned WORD_W       = 16;
  localparam logic [6:0]  DEF_DEV_ADDR = 7'h1A;

  typedef enum logic [3:0] {
    IDLE_S  = 4'd0,
    DELAY_S = 4'd1,
    LOAD_S  = 4'd2,
    REQ_S   = 4'd3,
    WAIT_S  = 4'd4,
    FAIL_S  = 4'd5,
    NEXT_S  = 4'd6,
    DONE_S  = 4'd7,
    ERROR_S = 4'd8
  } state_t;

endpackage

// File: rtl/i2c_cfg_sequencer_rom.sv
// Codec register write table: index -> {reg/data word}. Combinational lookup;
// any index beyond the populated entries returns zero.
module i2c_cfg_rom
  import i2c_cfg_pkg::*;
(
  input  logic [4:0]        index_i,
  output logic [WORD_W-1:0] word_o
);

  // Table lookup
  always_comb begin
    word_o = '0;
    case (index_i)
      5'd0:  word_o = 16'h1E00; // software reset
      5'd1:  word_o = 16'h0C10; // power down control
      5'd2:  word_o = 16'h0017; // left line in
      5'd3:  word_o = 16'h0217; // right line in
      5'd4:  word_o = 16'h0479; // left headphone out
      5'd5:  word_o = 16'h0679; // right headphone out
      5'd6:  word_o = 16'h0812; // analog audio path
      5'd7:  word_o = 16'h0A00; // digital audio path
      5'd8:  word_o = 16'h0E02; // digital interface format
      5'd9:  word_o = 16'h1000; // sampling control
      5'd10: word_o = 16'h1201; // activate interface
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// I2C codec configuration sequencer: after reset (or a start pulse) waits
// INIT_DELAY cycles, then hands each table word to the write transmitter,
// tracking done/NACK/timeout. Reports overall cfg_done / cfg_error.
// Optional feature macro: I2C_CFG_RETRY_EN (per-entry retry up to MAX_RETRY).
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 11,
  parameter logic [6:0]  DEV_ADDR   = DEF_DEV_ADDR,
  parameter int unsigned INIT_DELAY = 50000,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       tx_req,
  output logic [6:0] tx_dev_addr,
  output logic [7:0] tx_data1,
  output logic [7:0] tx_data2,
  input  logic       tx_done,
  input  logic       tx_nack,
  output logic [4:0] reg_index,
  output logic       cfg_done,
  output logic       cfg_error
);

  // One counter serves both the power-up delay and the transaction timeout,
  // so it is sized for the larger of the two.
  localparam int unsigned CNT_MAX = (INIT_DELAY > TIMEOUT) ? INIT_DELAY : TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(INIT_DELAY - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]       IDX_LAST = 5'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        idx_q, idx_d;
  logic [7:0]        d1_q, d1_d;
  logic [7:0]        d2_q, d2_d;
  logic [WORD_W-1:0] rom_word;

`ifdef I2C_CFG_RETRY_EN
  localparam int unsigned RTY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RTY_W-1:0] retry_q, retry_d;
`endif

  i2c_cfg_rom u_rom (
    .index_i (idx_q),
    .word_o  (rom_word)
  );

  // Next-state, counter and data-register update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
`ifdef I2C_CFG_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      IDLE_S: begin
        state_d = DELAY_S;
        cnt_d   = '0;
        idx_d   = '0;
`ifdef I2C_CFG_RETRY_EN
        retry_d = '0;
`endif
      end
      DELAY_S: begin
        if (cnt_q == DLY_LAST) begin
          state_d = LOAD_S;
          idx_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD_S: begin
        d1_d    = rom_word[15:8];
        d2_d    = rom_word[7:0];
        state_d = REQ_S;
      end
      REQ_S: begin
        cnt_d   = '0;
        state_d = WAIT_S;
      end
      WAIT_S: begin
        // A completion in the same cycle as the timeout takes priority.
        if (tx_done) begin
          state_d = tx_nack ? FAIL_S : NEXT_S;
        end else if (cnt_q == TO_LAST) begin
          state_d = FAIL_S;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FAIL_S: begin
`ifdef I2C_CFG_RETRY_EN
        if (retry_q < RTY_W'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = REQ_S;
        end else begin
          state_d = ERROR_S;
        end
`else
        state_d = ERROR_S;
`endif
      end
      NEXT_S: begin
`ifdef I2C_CFG_RETRY_EN
        retry_d = '0;
`endif
        if (idx_q == IDX_LAST) begin
          state_d = DONE_S;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD_S;
        end
      end
      DONE_S, ERROR_S: begin
        if (start) begin
          state_d = DELAY_S;
          cnt_d   = '0;
          idx_d   = '0;
`ifdef I2C_CFG_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE_S;
      cnt_q   <= '0;
      idx_q   <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
`ifdef I2C_CFG_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
`ifdef I2C_CFG_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign tx_req      = (state_q == REQ_S);
  assign cfg_done    = (state_q == DONE_S);
  assign cfg_error   = (state_q == ERROR_S);
  assign tx_dev_addr = DEV_ADDR;
  assign tx_data1    = d1_q;
  assign tx_data2    = d2_q;
  assign reg_index   = idx_q;

endmodule
